// File: rtl/lzd_reg.sv
// lzd_reg: registered leading-zero detector built from a balanced tree of 2-bit LZD leaves.
// Optional macro LZD_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).

module lzd_tree #(
    parameter int N = 16
) (
    input  logic [N-1:0]         a_i,
    output logic                 vld_o,
    output logic [$clog2(N)-1:0] cnt_o
);
    if (N == 2) begin : g_leaf
        assign vld_o = a_i[1] | a_i[0];
        assign cnt_o = ~a_i[1];
    end else begin : g_node
        localparam int H = N / 2;
        logic                 vl, vr;
        logic [$clog2(H)-1:0] cl, cr;

        lzd_tree #(.N(H)) u_hi (.a_i(a_i[N-1:H]), .vld_o(vl), .cnt_o(cl));
        lzd_tree #(.N(H)) u_lo (.a_i(a_i[H-1:0]), .vld_o(vr), .cnt_o(cr));

        // An empty upper half contributes all H of its zeros, hence the leading 1.
        assign vld_o = vl | vr;
        assign cnt_o = vl ? {1'b0, cl} : {1'b1, cr};
    end
endmodule

module lzd_reg #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N-1:0]         in,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out,
    output logic                 zero
);
    localparam int W = $clog2(N);

    logic         scan_vld;
    logic [N-1:0] scan_word;

`ifdef LZD_INPUT_REG_EN
    logic         in_valid_q;
    logic [N-1:0] in_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            in_q       <= '0;
        end else begin
            in_valid_q <= in_valid;
            in_q       <= in;
        end
    end

    assign scan_vld  = in_valid_q;
    assign scan_word = in_q;
`else
    assign scan_vld  = in_valid;
    assign scan_word = in;
`endif

    logic         tree_vld;
    logic [W-1:0] tree_cnt;

    lzd_tree #(.N(N)) u_tree (.a_i(scan_word), .vld_o(tree_vld), .cnt_o(tree_cnt));

    logic         out_valid_q;
    logic [W-1:0] out_q, out_d;
    logic         zero_q, zero_d;

    // Result registers hold across idle cycles; only the qualifier tracks every cycle.
    always_comb begin
        out_d  = out_q;
        zero_d = zero_q;
        if (scan_vld) begin
            out_d  = tree_cnt;
            zero_d = ~tree_vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= scan_vld;
            out_q       <= out_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_lzd_reg.sv
// Scoreboard bench for lzd_reg (N=16): stimulus pushes expected results, a monitor pops on out_valid.
module tb_lzd_reg;
    localparam int N = 16;
    localparam int W = 4;
`ifdef LZD_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [N-1:0] in = '0;
    logic         out_valid;
    logic [W-1:0] out;
    logic         zero;

    lzd_reg #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
        .out_valid(out_valid), .out(out), .zero(zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] out;
        logic         zero;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    endtask

    // Plain priority-encoder reference, scanning from the MSB.
    function automatic logic [W-1:0] ref_lzc(input logic [N-1:0] v);
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) return W'(N - 1 - i);
        return W'(N - 1);
    endfunction

    task automatic send(input logic [N-1:0] w, input logic [W-1:0] eo, input logic ez);
        @(posedge clk); #1;
        in       = w;
        in_valid = 1'b1;
        sb.push_back('{eo, ez, cyc});
    endtask

    task automatic idle(input logic [N-1:0] w);
        @(posedge clk); #1;
        in       = w;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("out", 32'(out), 32'(e.out));
                    chk("zero", 32'(zero), 32'(e.zero));
                    chk("latency", 32'(cyc - e.cyc), 32'(LAT));
                end
            end else if (sb.size() > 0 && (cyc - sb[0].cyc) >= LAT) begin
                chk("missing_valid", 32'(out_valid), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [N-1:0] w;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out",   32'(out),       32'd0);
        chk("rst_zero",  32'(zero),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(16'h8000, 4'd0,  1'b0);
        send(16'h7FFF, 4'd1,  1'b0);
        send(16'h00F0, 4'd8,  1'b0);
        send(16'h0001, 4'd15, 1'b0);
        send(16'h0000, 4'd15, 1'b1);

        send(16'h0100, 4'd7, 1'b0);
        for (int i = 0; i < 3 + LAT; i++) begin
            idle(16'hFFFF);
            @(negedge clk);
            if (i >= LAT) begin
                chk("hold_out",   32'(out),       32'd7);
                chk("hold_valid", 32'(out_valid), 32'd0);
                chk("hold_zero",  32'(zero),      32'd0);
            end
        end

        w = 16'h7FFF;
        for (int i = 0; i < 32; i++) begin
            send(w, (w == 16'h7FFF) ? 4'd1 : 4'd0, 1'b0);
            w = {w[0], w[N-1:1]};
        end

        // Reset with words in flight; everything outstanding is discarded.
        for (int i = 0; i < 4; i++) send(16'h1234, 4'd3, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_out",   32'(out),       32'd0);
        chk("midrst_zero",  32'(zero),      32'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_hold_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(16'h0000);
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        for (int v = 0; v < 65536; v++)
            send(N'(v), ref_lzc(N'(v)), (v == 0));

        for (int i = 0; i < LAT + 2; i++) idle(16'h0000);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
